// File: rtl/hex_token_pkg.sv
// Shared types and character constants for the hex token parser.
package hex_token_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SKIP  = 2'd2,
    EMIT  = 2'd3
  } state_t;

  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_A_UP = 8'h41;
  localparam logic [7:0] CH_F_UP = 8'h46;
  localparam logic [7:0] CH_A_LO = 8'h61;
  localparam logic [7:0] CH_F_LO = 8'h66;

endpackage

// File: rtl/hex_char_decode.sv
// Combinational ASCII classifier: hex digit -> nibble, plus delimiter detect.
// Lowercase 'a'-'f' are accepted as digits only when HEXPARSE_LOWERCASE_EN is defined.
module hex_char_decode
  import hex_token_pkg::*;
(
  input  logic [7:0] ch,
  output logic [3:0] nib,
  output logic       is_digit,
  output logic       is_delim
);

  always_comb begin
    nib      = 4'd0;
    is_digit = 1'b0;
    is_delim = (ch == CH_SP) || (ch == CH_LF) || (ch == CH_CR);
    if (ch >= CH_0 && ch <= CH_9) begin
      is_digit = 1'b1;
      nib      = 4'(ch - CH_0);
    end else if (ch >= CH_A_UP && ch <= CH_F_UP) begin
      is_digit = 1'b1;
      nib      = 4'(ch - CH_A_UP + 8'd10);
    end
`ifdef HEXPARSE_LOWERCASE_EN
    else if (ch >= CH_A_LO && ch <= CH_F_LO) begin
      is_digit = 1'b1;
      nib      = 4'(ch - CH_A_LO + 8'd10);
    end
`else
`endif
  end

endmodule

// File: rtl/hex_token_parser.sv
// Parses delimiter-terminated ASCII hex tokens into right-aligned words.
// Optional lowercase digit support via HEXPARSE_LOWERCASE_EN (decode only).
module hex_token_parser
  import hex_token_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [7:0]                     in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [4*DIGITS-1:0]            out_data,
  output logic [$clog2(DIGITS+1)-1:0]    out_ndig,
  output logic                           out_err,
  input  logic                           out_ready
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  state_t          state_q, state_n;
  logic [W-1:0]    acc_q, acc_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic            err_q, err_n;
  logic [3:0]      nib;
  logic            is_digit;
  logic            is_delim;
  logic            accept;

  hex_char_decode u_dec (
    .ch       (in_data),
    .nib      (nib),
    .is_digit (is_digit),
    .is_delim (is_delim)
  );

  assign accept = in_valid && in_ready;

  // Next-state and token datapath
  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    cnt_n   = cnt_q;
    err_n   = err_q;
    case (state_q)
      IDLE: begin
        if (accept && !is_delim) begin
          if (is_digit) begin
            acc_n   = W'(nib);
            cnt_n   = CW'(1);
            state_n = ACCUM;
          end else begin
            err_n   = 1'b1;
            state_n = SKIP;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (is_digit) begin
            if (cnt_q == CW'(DIGITS)) begin
              err_n   = 1'b1;
              state_n = SKIP;
            end else begin
              acc_n = (acc_q << 4) | W'(nib);
              cnt_n = cnt_q + CW'(1);
            end
          end else if (is_delim) begin
            state_n = EMIT;
          end else begin
            err_n   = 1'b1;
            state_n = SKIP;
          end
        end
      end
      SKIP: begin
        if (accept && is_delim) state_n = EMIT;
      end
      EMIT: begin
        if (out_valid && out_ready) begin
          acc_n   = '0;
          cnt_n   = '0;
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs, derived from next-state so they track EMIT exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ndig  <= '0;
      out_err   <= 1'b0;
    end else begin
      state_q   <= state_n;
      acc_q     <= acc_n;
      cnt_q     <= cnt_n;
      err_q     <= err_n;
      in_ready  <= (state_n != EMIT);
      out_valid <= (state_n == EMIT);
      out_data  <= (state_n == EMIT && !err_n) ? acc_n : '0;
      out_ndig  <= (state_n == EMIT && !err_n) ? cnt_n : '0;
      out_err   <= (state_n == EMIT) && err_n;
    end
  end

endmodule

// File: tb/tb_hex_token_parser.sv
// Directed self-checking bench for hex_token_parser (DIGITS=4).
module tb_hex_token_parser;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_ndig;
  logic        out_err;
  logic        out_ready;

  int total = 0;
  int bad   = 0;
  int hs_count = 0;

  hex_token_parser #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ndig  (out_ndig),
    .out_err   (out_err),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed result handshakes
  always @(posedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) hs_count <= hs_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one character at a negedge, wait for acceptance, return at the following negedge
  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = c;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Wait for a result, check its fields, and let the handshake complete if out_ready is high
  task automatic expect_result(input string tag, input logic [15:0] d,
                               input logic [2:0] nd, input logic e);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_ndig"},  32'(out_ndig),  32'(nd));
    chk({tag, "_err"},   32'(out_err),   32'(e));
    if (out_ready === 1'b1) @(negedge clk);
  endtask

  initial begin
    int hs0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_ndig",  32'(out_ndig),  32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Full-width token, latency of one cycle after the delimiter
    send_str("1A3F");
    chk("t1_no_early_valid", 32'(out_valid), 32'd0);
    send(8'h20);
    chk("t1_latency", 32'(out_valid), 32'd1);
    expect_result("t1", 16'h1A3F, 3'd4, 1'b0);
    chk("t1_hs", 32'(hs_count), 32'd1);
    chk("t1_valid_drop", 32'(out_valid), 32'd0);

    // Leading delimiters ignored
    send_str("  7");
    send(8'h0A);
    expect_result("t2", 16'h0007, 3'd1, 1'b0);
    repeat (4) @(negedge clk);
    chk("t2_no_extra", 32'(hs_count), 32'd2);

    // Invalid character mid-token, then recovery
    send_str("12G4 ");
    expect_result("t3", 16'h0000, 3'd0, 1'b1);
    send(8'h35);
    send(8'h0D);
    expect_result("t3b", 16'h0005, 3'd1, 1'b0);

    // Overflow on fifth digit
    send_str("12345 ");
    expect_result("t4", 16'h0000, 3'd0, 1'b1);
    chk("t4_hs", 32'(hs_count), 32'd5);

    // Back-pressure: result held stable, input stalled
    out_ready = 1'b0;
    send_str("BEEF ");
    hs0 = hs_count;
    for (int i = 0; i < 6; i++) begin
      chk("t5_hold_valid", 32'(out_valid), 32'd1);
      chk("t5_hold_data",  32'(out_data),  32'hBEEF);
      chk("t5_hold_ready", 32'(in_ready),  32'd0);
      @(negedge clk);
    end
    chk("t5_ndig", 32'(out_ndig), 32'd4);
    chk("t5_no_hs", 32'(hs_count), 32'(hs0));
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_one_hs",  32'(hs_count),  32'(hs0 + 1));
    chk("t5_valid_0", 32'(out_valid), 32'd0);
    chk("t5_ready_1", 32'(in_ready),  32'd1);
    @(negedge clk);
    chk("t5_still_one_hs", 32'(hs_count), 32'(hs0 + 1));

    // Reset mid-token drops the partial token
    hs0 = hs_count;
    send_str("12");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    send_str("5 ");
    expect_result("t6", 16'h0005, 3'd1, 1'b0);
    chk("t6_hs", 32'(hs_count), 32'(hs0 + 1));

    // Reset during a pending result drops it
    out_ready = 1'b0;
    send_str("9 ");
    chk("t7_pending", 32'(out_valid), 32'd1);
    hs0 = hs_count;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("t7_rst_valid", 32'(out_valid), 32'd0);
    chk("t7_rst_ready", 32'(in_ready),  32'd1);
    repeat (3) @(negedge clk);
    chk("t7_no_hs", 32'(hs_count), 32'(hs0));

    // Lowercase digits depend on build option
    send_str("ff ");
`ifdef HEXPARSE_LOWERCASE_EN
    expect_result("t8", 16'h00FF, 3'd2, 1'b0);
`else
    expect_result("t8", 16'h0000, 3'd0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
